// File: rtl/i2c_pkg.sv
// Shared I2C definitions: arbiter FSM states, status codes and field widths
// reused by the arbiter and the I2C_master1 engine.
package i2c_pkg;

   localparam int unsigned I2C_ADDR_W = 7;
   localparam int unsigned I2C_DATA_W = 8;

   localparam logic [1:0] I2C_ST_OK      = 2'b00;
   localparam logic [1:0] I2C_ST_NACK    = 2'b01;
   localparam logic [1:0] I2C_ST_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_LAUNCH,
      ARB_WAIT,
      ARB_COMPLETE
   } arb_state_t;

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit scanning upward
// from rr_ptr, wrapping at NUM_REQ.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic               any
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      gnt = '0;
      any = 1'b0;
      idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!any && req[idx]) begin
            gnt[idx] = 1'b1;
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master engine among NUM_REQ requesters,
// with a watchdog that aborts transactions the engine never completes.
module i2c_req_arbiter
   import i2c_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ-1:0]      req_rw,
   input  logic [7*NUM_REQ-1:0]    req_slave_addr,
   input  logic [8*NUM_REQ-1:0]    req_reg_addr,
   input  logic [8*NUM_REQ-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      done,
   output logic [7:0]              rdata,
   output logic [1:0]              status,
   output logic                    m_enable,
   output logic [6:0]              m_slave_addr,
   output logic [7:0]              m_reg_addr,
   output logic [7:0]              m_data_in,
   output logic                    m_read_write,
   input  logic                    m_done,
   input  logic                    m_nack,
   input  logic [7:0]              m_rdata
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC);

   arb_state_t         state, state_nxt;
   logic [WD_W-1:0]    wd, wd_nxt;
   logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [PTR_W-1:0]   gnt_idx, gnt_idx_nxt;
   logic [PTR_W-1:0]   pick_idx;
   logic [NUM_REQ-1:0] pick_gnt;
   logic               pick_any;

   logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
   logic [7:0]         rdata_nxt, m_reg_addr_nxt, m_data_in_nxt;
   logic [1:0]         status_nxt;
   logic [6:0]         m_slave_addr_nxt;
   logic               m_enable_nxt, m_read_write_nxt;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .gnt    (pick_gnt),
      .any    (pick_any)
   );

   always_comb begin
      pick_idx = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (pick_gnt[k]) pick_idx = PTR_W'(k);
      end
   end

   always_comb begin
      state_nxt        = state;
      wd_nxt           = wd;
      rr_ptr_nxt       = rr_ptr;
      gnt_idx_nxt      = gnt_idx;
      gnt_nxt          = gnt;
      done_nxt         = '0;
      rdata_nxt        = rdata;
      status_nxt       = status;
      m_enable_nxt     = m_enable;
      m_slave_addr_nxt = m_slave_addr;
      m_reg_addr_nxt   = m_reg_addr;
      m_data_in_nxt    = m_data_in;
      m_read_write_nxt = m_read_write;

      case (state)
         ARB_IDLE: begin
            if (pick_any) begin
               gnt_nxt          = pick_gnt;
               gnt_idx_nxt      = pick_idx;
               m_slave_addr_nxt = req_slave_addr[pick_idx*I2C_ADDR_W +: I2C_ADDR_W];
               m_reg_addr_nxt   = req_reg_addr[pick_idx*I2C_DATA_W +: I2C_DATA_W];
               m_data_in_nxt    = req_wdata[pick_idx*I2C_DATA_W +: I2C_DATA_W];
               m_read_write_nxt = req_rw[pick_idx];
               state_nxt        = ARB_LAUNCH;
            end
         end
         ARB_LAUNCH: begin
            m_enable_nxt = 1'b1;
            wd_nxt       = '0;
            state_nxt    = ARB_WAIT;
         end
         ARB_WAIT: begin
            // m_done is tested first so it wins over a coincident terminal count
            if (m_done) begin
               rdata_nxt    = m_rdata;
               status_nxt   = m_nack ? I2C_ST_NACK : I2C_ST_OK;
               m_enable_nxt = 1'b0;
               done_nxt     = gnt;
               state_nxt    = ARB_COMPLETE;
            end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
               status_nxt   = I2C_ST_TIMEOUT;
               m_enable_nxt = 1'b0;
               done_nxt     = gnt;
               state_nxt    = ARB_COMPLETE;
            end else begin
               wd_nxt = wd + 1'b1;
            end
         end
         ARB_COMPLETE: begin
            gnt_nxt    = '0;
            rr_ptr_nxt = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            state_nxt  = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= ARB_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wd           <= '0;
         rr_ptr       <= '0;
         gnt_idx      <= '0;
         gnt          <= '0;
         done         <= '0;
         rdata        <= '0;
         status       <= I2C_ST_OK;
         m_enable     <= 1'b0;
         m_slave_addr <= '0;
         m_reg_addr   <= '0;
         m_data_in    <= '0;
         m_read_write <= 1'b0;
      end else begin
         wd           <= wd_nxt;
         rr_ptr       <= rr_ptr_nxt;
         gnt_idx      <= gnt_idx_nxt;
         gnt          <= gnt_nxt;
         done         <= done_nxt;
         rdata        <= rdata_nxt;
         status       <= status_nxt;
         m_enable     <= m_enable_nxt;
         m_slave_addr <= m_slave_addr_nxt;
         m_reg_addr   <= m_reg_addr_nxt;
         m_data_in    <= m_data_in_nxt;
         m_read_write <= m_read_write_nxt;
      end
   end

endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Round-robin arbiter and transaction sequencer that shares one I2C master engine (the `I2C_master1` register-access engine) between up to `NUM_REQ` on-chip requesters. It latches one requester's slave address, register address, write data and direction, then drives the master's command inputs and holds `m_enable` until the engine reports completion. It returns read data and a status code to the granted requester. A watchdog counter aborts a hung transaction so that the shared bus can never stall forever.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, 4096: max `clk` cycles in WAIT before abort; must be ≥ 4.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low (0 = reset, sampled on `clk` rising edge).
- `req`  in  NUM_REQ: per-requester transaction request, level.
- `req_rw`  in  NUM_REQ: per-requester direction, 1 = read, 0 = write.
- `req_slave_addr`  in  7*NUM_REQ: packed 7-bit slave addresses, requester i at [7i+6:7i].
- `req_reg_addr`  in  8*NUM_REQ: packed register addresses.
- `req_wdata`  in  8*NUM_REQ: packed write data.
- `gnt`  out  NUM_REQ: one-hot grant, held for the whole transaction.
- `done`  out  NUM_REQ: one-cycle completion pulse to the granted requester.
- `rdata`  out  8: read data, valid in the `done` cycle.
- `status`  out  2: 00 OK, 01 NACK, 10 TIMEOUT; valid in the `done` cycle.
- `m_enable`  out  1: transaction enable to the master engine.
- `m_slave_addr`  out  7: to master `ext_slave_addr`.
- `m_reg_addr`  out  8: to master `ext_reg_addr`.
- `m_data_in`  out  8: to master `data_in`.
- `m_read_write`  out  1: to master `read_write`.
- `m_done`  in  1: master completion pulse, one cycle.
- `m_nack`  in  1: master NACK flag, valid with `m_done`.
- `m_rdata`  in  8: master read byte, valid with `m_done`.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, COMPLETE.
- IDLE, no `req` bit set: stay in IDLE.
- IDLE, any `req` bit set:
  - Select the first set bit scanning from `rr_ptr` upward, wrapping at `NUM_REQ`.
  - Register one-hot `gnt`.
  - Latch that requester's address, register, data and direction fields into the `m_*` registers.
  - Go to LAUNCH.
- LAUNCH: `m_enable`=1; `m_done` is ignored; go to WAIT.
- WAIT:
  - `m_enable` stays 1; the watchdog increments every cycle.
  - `m_done`=1: capture `m_rdata`, set `status` to 01 if `m_nack` else 00, go to COMPLETE.
  - Watchdog reaches TIMEOUT_CYC-1 without `m_done`: `status`=10, `rdata` is left unchanged, go to COMPLETE.
- COMPLETE:
  - `m_enable`=0; `done[i]`=1 for exactly this cycle; `gnt` drops at the end of the cycle.
  - `rr_ptr` ← (i+1) mod NUM_REQ.
  - Go to IDLE.
- Latched fields are frozen from the grant onward. Requester input changes mid-transaction have no effect.
- `req[i]` deasserting mid-transaction: the transaction still completes and `done[i]` still pulses.
- `req[i]` still high in the cycle after `done`: treated as a new request; round-robin gives other pending requesters priority first.
- `m_done` in the same cycle as the timeout terminal count: `m_done` wins, status 00/01.
- `m_done` while in IDLE or COMPLETE: ignored.
- Reset asserted at any cycle, including mid-transaction:
  - Next edge returns the FSM to IDLE.
  - `m_enable`=0, `gnt`=0, `done`=0.
  - `status`=00, `rdata`=0, `m_*` fields = 0, `rr_ptr`=0, watchdog=0.
  - No `done` pulse is emitted for the aborted transaction.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `req` seen in IDLE at edge t: `gnt` and `m_*` fields valid after t, `m_enable`=1 after t+1.
- Minimum occupancy: 4 cycles (IDLE → LAUNCH → WAIT → COMPLETE), with `m_done` in the first WAIT cycle.
- `m_done` at edge d: `done`, `rdata`, `status` valid in cycle d+1; arbiter back in IDLE at d+2.
- Back-to-back transactions: IDLE occupies one cycle between COMPLETE and the next LAUNCH.
- Timeout: `done` asserts TIMEOUT_CYC+1 cycles after LAUNCH.

## Structure
- Shared package `i2c_pkg` holds:
  - FSM state encoding.
  - Status constants `I2C_ST_OK`, `I2C_ST_NACK`, `I2C_ST_TIMEOUT`.
  - Address/data width constants (7, 8) for reuse by the master engine.
- One sub-module, `rr_pick`: combinational round-robin priority selector. Inputs: `req` and `rr_ptr`. Outputs: one-hot grant and `any`.
- Watchdog counter width: $clog2(TIMEOUT_CYC).

## Test plan
- Single write: reset low 2 cycles, then `req[2]`=1, rw=0, slave 7'h69, reg 8'h1A, data 8'hC3; `m_done` 5 cycles after `m_enable`. Expect `gnt`=4'b0100, `m_*` = 69/1A/C3/0, `done[2]` one pulse, `status`=00.
- Read with NACK: `req[0]` read, `m_done`=1 with `m_nack`=1 and `m_rdata`=8'h5E. Expect `rdata`=8'h5E, `status`=01, `done`=4'b0001.
- Round-robin fairness: `req`=4'b1111 held continuously, each transaction completed. Expect grant order 0,1,2,3,0, with one IDLE cycle between COMPLETE and the next LAUNCH.
- Timeout: TIMEOUT_CYC=16, `m_done` never asserted. Expect `m_enable` low and `done` pulsing 17 cycles after LAUNCH, `status`=10; next request serviced normally.
- Reset mid-transaction: assert `reset`=0 in WAIT. Expect next-cycle `m_enable`=0, `gnt`=0, no `done` pulse; after release, `req[1]` is granted first (`rr_ptr`=0 scan).
- Simultaneous `m_done` and timeout: assert `m_done` exactly at the terminal count. Expect `status`=00 and `rdata` = `m_rdata`.
